instr_mem_fetch: RTL
====================

INSTR_MEM_FETCH -- requirements
Module: instr_mem_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, meaning the number of word-index bits (DEPTH = 2^ADDR_WIDTH words of 32 bits).
REQ-002 SHALL have parameter NOP_WORD, default 32'h00000013, meaning the value written into every word during initialisation.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  fetch request present.
REQ-006 SHALL have port req_ready  output  1  fetch request accepted this cycle.
REQ-007 SHALL have port req_addr  input  32  byte address of the fetch.
REQ-008 SHALL have port resp_valid  output  1  response register holds data.
REQ-009 SHALL have port resp_ready  input  1  consumer takes the response.
REQ-010 SHALL have port resp_instr  output  32  fetched instruction.
REQ-011 SHALL have port resp_fault  output  2  fault code: 00 none, 01 misaligned, 10 out-of-range.
REQ-012 SHALL have port ld_en  input  1  program-load write strobe.
REQ-013 SHALL have port ld_addr  input  ADDR_WIDTH  word index to write.
REQ-014 SHALL have port ld_data  input  32  word to write.
REQ-015 SHALL have port init_done  output  1  high once initialisation has completed.

Function
REQ-016 SHALL implement a two-state FSM: INIT (clear memory) and RUN.
REQ-017 In INIT, SHALL write NOP_WORD to word index init_cnt each cycle, increment init_cnt from 0, and move to RUN on the cycle after writing index DEPTH-1 (DEPTH cycles in INIT).
REQ-018 In INIT, SHALL hold req_ready=0 and init_done=0, and SHALL ignore ld_en.
REQ-019 In RUN, SHALL hold init_done=1 and SHALL write ld_data to memory[ld_addr] on each clock edge with ld_en=1.
REQ-020 SHALL drive req_ready = RUN && (!resp_valid || resp_ready).
REQ-021 A request SHALL be accepted on an edge with req_valid && req_ready.
REQ-022 On acceptance, SHALL load the response register on that edge, giving 1-cycle latency, and SHALL set resp_valid=1.
REQ-023 SHALL return resp_fault=01 and resp_instr=NOP_WORD when req_addr[1:0]!=0 (misaligned takes priority).
REQ-024 Otherwise, SHALL return resp_fault=10 and resp_instr=NOP_WORD when req_addr[31:ADDR_WIDTH+2]!=0.
REQ-025 Otherwise, SHALL return resp_fault=00 and resp_instr=memory[req_addr[ADDR_WIDTH+1:2]].
REQ-026 SHALL hold resp_instr, resp_fault and resp_valid stable while resp_valid && !resp_ready (stall).
REQ-027 SHALL clear resp_valid when resp_ready=1 and no new request is accepted on that edge.
REQ-028 On a simultaneous response handoff and new acceptance, resp_valid SHALL stay 1 with the new data (full throughput: one fetch per cycle).
REQ-029 On a same-cycle ld_en write and fetch of the same word, the fetch SHALL return the old (pre-write) data.
REQ-030 On a same-cycle ld_en write and fetch of different words, both SHALL complete independently.

Reset
REQ-031 Assertion of reset_n=0 SHALL asynchronously force state=INIT, init_cnt=0, resp_valid=0, resp_instr=0, resp_fault=00, init_done=0 and req_ready=0.
REQ-032 Reset asserted mid-INIT or mid-RUN SHALL restart the full clear sequence after release.
REQ-033 A response pending at reset SHALL be discarded.
REQ-034 Memory contents SHALL NOT be modified by reset itself; only the INIT sweep SHALL modify them.

Verification
REQ-035 Bench SHALL check: release reset with ADDR_WIDTH=5 -> init_done rises after exactly 32 cycles, and a fetch of every address 0x00..0x7C returns 32'h00000013 with fault 00.
REQ-036 Bench SHALL check: load word 3 = 32'h003080B3, then fetch 0x0C -> next cycle resp_valid=1, resp_instr=32'h003080B3, fault 00.
REQ-037 Bench SHALL check: fetch 0x06 -> fault 01, instr 32'h00000013; fetch 0x80 -> fault 10; fetch 0x82 -> fault 01.
REQ-038 Bench SHALL check: back-to-back requests at 0x00, 0x04 and 0x08 with resp_ready held low for 3 cycles after the first response -> the first response is held, req_ready=0 during the stall, all three responses arrive in order, and none are lost.
REQ-039 Bench SHALL check: same-cycle ld_en to word 2 with data 32'hDEADBEEF and a fetch of 0x08 -> the fetch returns the old word, and a refetch returns 32'hDEADBEEF.
REQ-040 Bench SHALL check: reset pulsed during RUN with a response pending -> resp_valid drops immediately, INIT reruns for 32 cycles, and loaded words read back as NOP_WORD.

Source files
------------

// File: rtl/instr_mem_fetch.sv
// Instruction memory with a fetch port and a program-load write port.
// After reset the whole array is swept to NOP_WORD before fetches are accepted.
module instr_mem_fetch #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_instr,
  output logic [1:0]            resp_fault,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [31:0]           ld_data,
  output logic                  init_done
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_instr_q, resp_instr_d;
  logic [1:0]            resp_fault_q, resp_fault_d;

  logic [31:0]           mem_q [DEPTH];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [31:0]           mem_wdata;

  logic                  accept;
  logic                  misaligned;
  logic                  out_of_range;
  logic [ADDR_WIDTH-1:0] fetch_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= INIT;
      init_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_instr_q <= 32'd0;
      resp_fault_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_instr_q <= resp_instr_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  // Memory is deliberately not reset; only the INIT sweep or program loads change it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    mem_we     = 1'b0;
    mem_waddr  = ld_addr;
    mem_wdata  = ld_data;
    init_done  = 1'b0;
    unique case (state_q)
      INIT: begin
        mem_we     = 1'b1;
        mem_waddr  = init_cnt_q;
        mem_wdata  = NOP_WORD;
        init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
        if (init_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        init_done = 1'b1;
        mem_we    = ld_en;
      end
      default: state_d = INIT;
    endcase
  end

  assign req_ready = (state_q == RUN) && (!resp_valid_q || resp_ready);

  // The read uses the pre-edge array, so a same-word load returns the old data.
  always_comb begin
    misaligned   = (req_addr[1:0] != 2'b00);
    out_of_range = ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    fetch_idx    = req_addr[ADDR_WIDTH+1:2];
    accept       = req_valid && req_ready;
    resp_valid_d = resp_valid_q;
    resp_instr_d = resp_instr_q;
    resp_fault_d = resp_fault_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      if (misaligned) begin
        resp_fault_d = 2'b01;
        resp_instr_d = NOP_WORD;
      end else if (out_of_range) begin
        resp_fault_d = 2'b10;
        resp_instr_d = NOP_WORD;
      end else begin
        resp_fault_d = 2'b00;
        resp_instr_d = mem_q[fetch_idx];
      end
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_instr = resp_instr_q;
  assign resp_fault = resp_fault_q;

endmodule
